// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one combinational ALU through an arbiter.
// The granted operation is evaluated and captured, with its zero flag and
// requester ID, in a one-entry output register drained by a valid/ready port.
// Build option: define ALU_ARB_FIXED_PRIO_EN to make requester 0 always win
// contention (no last_grant state); otherwise arbitration is round-robin.
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_ctrl,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_ctrl,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_result,
    output logic             resp_zero,
    output logic             resp_id
);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_SLT = 3'b101
    } alu_op_e;

    logic             can_load;   // output register is free or being drained
    logic             gnt_any;    // some requester is asking
    logic             gnt_id;     // requester chosen this cycle
    logic             accept;     // the granted request is taken this cycle
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [2:0]       sel_ctrl;
    logic [WIDTH-1:0] alu_result;

    assign can_load = !resp_valid || resp_ready;
    assign gnt_any  = req0_valid || req1_valid;
    assign accept   = gnt_any && can_load;

    assign req0_ready = accept && !gnt_id;
    assign req1_ready = accept && gnt_id;

    // Operand mux driven by the grant.
    assign sel_a    = gnt_id ? req1_a    : req0_a;
    assign sel_b    = gnt_id ? req1_b    : req0_b;
    assign sel_ctrl = gnt_id ? req1_ctrl : req0_ctrl;

    // Shared ALU: modulo-2^WIDTH arithmetic, unused encodings yield zero.
    always_comb begin
        // NOTE: default assigned first so every path drives alu_result; a missing default would infer a latch.
        alu_result = '0;
        case (sel_ctrl)
            OP_ADD:  alu_result = sel_a + sel_b;
            OP_SUB:  alu_result = sel_a - sel_b;
            OP_AND:  alu_result = sel_a & sel_b;
            OP_OR:   alu_result = sel_a | sel_b;
            OP_SLT:  alu_result = {{(WIDTH-1){1'b0}}, ($signed(sel_a) < $signed(sel_b))};
            default: alu_result = '0;
        endcase
    end

    // One-entry output register: load on acceptance, clear valid on a pure drain.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: the result fields are reset as well because they are visible on resp_* straight after reset.
        if (reset) begin
            resp_valid  <= 1'b0;
            resp_result <= '0;
            resp_zero   <= 1'b0;
            resp_id     <= 1'b0;
        end else if (accept) begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
            resp_valid  <= 1'b1;
            resp_result <= alu_result;
            resp_zero   <= (alu_result == '0);
            resp_id     <= gnt_id;
        end else if (resp_ready) begin
            resp_valid  <= 1'b0;
        end
    end

`ifdef ALU_ARB_FIXED_PRIO_EN
    // Fixed priority: requester 1 is chosen only while requester 0 is idle.
    assign gnt_id = !req0_valid;
`else
    logic last_grant;   // requester accepted most recently

    // Round-robin grant: on contention pick the requester that did not win last.
    always_comb begin
        gnt_id = 1'b0;
        if (req0_valid && req1_valid) begin
            gnt_id = !last_grant;
        end else if (req1_valid) begin
            gnt_id = 1'b1;
        end
    end

    // Remember the last accepted requester; reset to 1 so requester 0 wins first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= gnt_id;
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed literal checks plus randomized traffic compared
// every cycle against a behavioural model of the arbiter and result register.
module tb_alu_arbiter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         req0_valid = 1'b0;
    logic [W-1:0] req0_a = '0;
    logic [W-1:0] req0_b = '0;
    logic [2:0]   req0_ctrl = '0;
    logic         req1_valid = 1'b0;
    logic [W-1:0] req1_a = '0;
    logic [W-1:0] req1_b = '0;
    logic [2:0]   req1_ctrl = '0;
    logic         resp_ready = 1'b0;
    logic         req0_ready;
    logic         req1_ready;
    logic         resp_valid;
    logic [W-1:0] resp_result;
    logic         resp_zero;
    logic         resp_id;

    int n_checks = 0;
    int n_fail = 0;

    // Behavioural model state.
    logic         m_valid = 1'b0;
    logic [W-1:0] m_result = '0;
    logic         m_zero = 1'b0;
    logic         m_id = 1'b0;
    logic         m_last = 1'b1;
    int           m_w;
    int           c_w;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk(clk),
        .reset(reset),
        .req0_valid(req0_valid),
        .req0_ready(req0_ready),
        .req0_a(req0_a),
        .req0_b(req0_b),
        .req0_ctrl(req0_ctrl),
        .req1_valid(req1_valid),
        .req1_ready(req1_ready),
        .req1_a(req1_a),
        .req1_b(req1_b),
        .req1_ctrl(req1_ctrl),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_result(resp_result),
        .resp_zero(resp_zero),
        .resp_id(resp_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference ALU straight from the operation table.
    function automatic logic [W-1:0] ref_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [2:0] op);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd5:    return ($signed(a) < $signed(b)) ? 1 : 0;
            default: return 0;
        endcase
    endfunction

    // Which requester is taken this cycle (-1 when none), from the grant rules.
    function automatic int ref_accept();
        int w;
        w = -1;
        if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            w = 0;
`else
            w = (m_last == 1'b0) ? 1 : 0;
`endif
        end else if (req0_valid) begin
            w = 0;
        end else if (req1_valid) begin
            w = 1;
        end
        if (m_valid && !resp_ready) w = -1;
        return w;
    endfunction

    // Model update at each edge; async reset clears it immediately.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid = 1'b0; m_result = '0; m_zero = 1'b0; m_id = 1'b0; m_last = 1'b1;
        end else begin
            m_w = ref_accept();
            if (m_w == 0) begin
                m_result = ref_alu(req0_a, req0_b, req0_ctrl);
                m_valid = 1'b1; m_zero = (m_result == 0); m_id = 1'b0; m_last = 1'b0;
            end else if (m_w == 1) begin
                m_result = ref_alu(req1_a, req1_b, req1_ctrl);
                m_valid = 1'b1; m_zero = (m_result == 0); m_id = 1'b1; m_last = 1'b1;
            end else if (resp_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    // Compare DUT against the model every cycle, away from the active edge.
    always @(negedge clk) begin
        c_w = ref_accept();
        check("model req0_ready", req0_ready, c_w == 0);
        check("model req1_ready", req1_ready, c_w == 1);
        check("model resp_valid", resp_valid, m_valid);
        check("model resp_result", resp_result, m_result);
        check("model resp_zero", resp_zero, m_zero);
        check("model resp_id", resp_id, m_id);
    end

    task automatic set_req(input int n, input logic v, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [2:0] c);
        if (n == 0) begin
            req0_valid = v; req0_a = a; req0_b = b; req0_ctrl = c;
        end else begin
            req1_valid = v; req1_a = a; req1_b = b; req1_ctrl = c;
        end
    endtask

    // Single request from one requester with resp_ready high; entered and left #1 after an edge.
    task automatic single_op(input int n, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [2:0] c, input logic [W-1:0] exp_r,
                             input logic exp_z, input string name);
        set_req(n, 1'b1, a, b, c);
        #2;
        check({name, " ready"}, (n == 0) ? req0_ready : req1_ready, 1);
        @(posedge clk); #1;
        set_req(n, 1'b0, '0, '0, 3'd0);
        check({name, " valid"}, resp_valid, 1);
        check({name, " result"}, resp_result, exp_r);
        check({name, " zero"}, resp_zero, exp_z);
        check({name, " id"}, resp_id, (n == 0) ? 0 : 1);
    endtask

    function automatic logic [W-1:0] rand_operand();
        if ($urandom_range(0, 3) == 0) return W'($urandom_range(0, 3));
        return W'($urandom());
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  exp_g;
        int  p0;
        int  p1;
        logic acc0;
        logic acc1;

        resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("reset resp_valid", resp_valid, 0);
        check("reset resp_result", resp_result, 0);
        check("reset resp_zero", resp_zero, 0);
        check("reset resp_id", resp_id, 0);

        // Operation coverage.
        single_op(0, 5, 7, 3'b000, 12, 1'b0, "add 5+7");
        single_op(0, 32'h8000_0000, 1, 3'b101, 1, 1'b0, "slt min<1");
        single_op(0, 32'h8000_0000, 1, 3'b001, 32'h7fff_ffff, 1'b0, "sub min-1");
        single_op(1, 9, 9, 3'b001, 0, 1'b1, "sub 9-9");
        single_op(0, 32'h8000_0000, 1, 3'b111, 0, 1'b1, "op 111");
        single_op(1, 32'hffff_ffff, 1, 3'b000, 0, 1'b1, "add wrap");
        single_op(0, 32'h0000_f0f0, 32'h0000_0ff0, 3'b011, 32'h0000_fff0, 1'b0, "or");
        single_op(0, 32'hffff_fffb, 5, 3'b101, 1, 1'b0, "slt -5<5");
        single_op(0, 5, 32'hffff_fffb, 3'b101, 0, 1'b1, "slt 5<-5");
        single_op(1, 3, 3, 3'b010, 3, 1'b0, "and r1");

        // Contention for 4 cycles: alternating grants (fixed priority: all to 0).
        p0 = 10; p1 = 20;
        set_req(0, 1'b1, W'(p0), 1, 3'b000);
        set_req(1, 1'b1, W'(p1), 2, 3'b001);
        for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            exp_g = 0;
`else
            exp_g = i % 2;
`endif
            #2;
            check("contend req0_ready", req0_ready, exp_g == 0);
            check("contend req1_ready", req1_ready, exp_g == 1);
            @(posedge clk); #1;
            check("contend resp_valid", resp_valid, 1);
            check("contend resp_id", resp_id, exp_g);
            check("contend resp_result", resp_result, (exp_g == 0) ? W'(p0 + 1) : W'(p1 - 2));
            if (exp_g == 0) begin
                p0++; set_req(0, 1'b1, W'(p0), 1, 3'b000);
            end else begin
                p1++; set_req(1, 1'b1, W'(p1), 2, 3'b001);
            end
        end

        // Load 42, then backpressure for 3 cycles with both requesters waiting.
        set_req(1, 1'b0, '0, '0, 3'd0);
        set_req(0, 1'b1, 20, 22, 3'b000);
        @(posedge clk); #1;
        check("bp load result", resp_result, 42);
        resp_ready = 1'b0;
        set_req(0, 1'b1, 1, 1, 3'b000);
        set_req(1, 1'b1, 7, 2, 3'b001);
        for (int i = 0; i < 3; i++) begin
            #2;
            check("bp req0_ready", req0_ready, 0);
            check("bp req1_ready", req1_ready, 0);
            @(posedge clk); #1;
            check("bp resp_valid", resp_valid, 1);
            check("bp resp_result", resp_result, 42);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        check("no bubble resp_valid", resp_valid, 1);
`ifdef ALU_ARB_FIXED_PRIO_EN
        check("no bubble resp_result", resp_result, 2);
        check("no bubble resp_id", resp_id, 0);
`else
        check("no bubble resp_result", resp_result, 5);
        check("no bubble resp_id", resp_id, 1);
`endif

        // Asynchronous reset mid-cycle while a result is held.
        set_req(0, 1'b0, '0, '0, 3'd0);
        set_req(1, 1'b0, '0, '0, 3'd0);
        resp_ready = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("async reset resp_valid", resp_valid, 0);
        check("async reset resp_result", resp_result, 0);
        check("async reset resp_id", resp_id, 0);
        set_req(0, 1'b1, 1, 2, 3'b000);
        set_req(1, 1'b1, 4, 1, 3'b001);
        resp_ready = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        #2;
        check("post reset req0_ready", req0_ready, 1);
        check("post reset req1_ready", req1_ready, 0);
        @(posedge clk); #1;
        check("post reset resp_id", resp_id, 0);
        check("post reset resp_result", resp_result, 3);
        set_req(0, 1'b0, '0, '0, 3'd0);
        @(posedge clk); #1;
        set_req(1, 1'b0, '0, '0, 3'd0);

        // Randomized traffic; requesters hold payload until accepted.
        for (int i = 0; i < 2000; i++) begin
            #3;
            acc0 = req0_valid && req0_ready;
            acc1 = req1_valid && req1_ready;
            @(posedge clk); #1;
            if (!req0_valid || acc0)
                set_req(0, $urandom_range(0, 2) != 0, rand_operand(), rand_operand(), 3'($urandom_range(0, 7)));
            if (!req1_valid || acc1)
                set_req(1, $urandom_range(0, 2) != 0, rand_operand(), rand_operand(), 3'($urandom_range(0, 7)));
            resp_ready = ($urandom_range(0, 3) != 0);
        end

        #3;
        acc0 = req0_valid && req0_ready;
        acc1 = req1_valid && req1_ready;
        @(posedge clk); #1;
        if (acc0) set_req(0, 1'b0, '0, '0, 3'd0);
        if (acc1) set_req(1, 1'b0, '0, '0, 3'd0);
        resp_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        set_req(0, 1'b0, '0, '0, 3'd0);
        set_req(1, 1'b0, '0, '0, 3'd0);
        repeat (2) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
